watchdog_reset_sequencer: RTL and testbench
===========================================

# watchdog_reset_sequencer

Multi-source watchdog supervisor that sequences the system reset path for the OpenSSD platform. Each enabled heartbeat source must kick at least once per timeout window. A missed window triggers a fixed-length registered reset pulse, then a boot grace period, then automatic re-arming. Status outputs record which sources missed their window and how many resets have fired.

## Interface

- `NUM_SRC`, default 4: number of heartbeat sources.
- `TIMEOUT_CYCLES`, default 500_000_000: window length in cycles (5 s at 100 MHz); must be ≥2.
- `HOLD_CYCLES`, default 1000: reset pulse length; must be ≥1.
- `GRACE_CYCLES`, default 100_000_000: post-reset boot window; 0 allowed.
- `CNT_W`, default 32: counter width; must hold max(TIMEOUT, HOLD, GRACE) − 1.

Ports:

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: supervisor enable (level).
- `kick` in NUM_SRC: per-source heartbeat, level-sampled every cycle.
- `src_mask` in NUM_SRC: 1 = source participates; sampled every cycle.
- `reset_out` out 1: registered system reset request.
- `wdt_state` out 2: current FSM state.
- `timeout_src` out NUM_SRC: sources missing in the last timed-out window.
- `reset_count` out 8: resets fired, saturating.

## Operation

- States: IDLE=0, ARMED=1, RESET=2, GRACE=3.
- One shared down-phase counter `cnt`, cleared on every state entry.
- IDLE:
  - `cnt` held at 0; `seen` held at 0.
  - `enable`=1 → ARMED.
- ARMED:
  - `seen |= kick & src_mask` each cycle; `cnt` increments.
  - Round complete when `(seen | kick) & src_mask == src_mask` → next cycle `seen`=0, `cnt`=0.
  - `src_mask`=0 counts as complete every cycle, so no timeout is possible.
  - `cnt == TIMEOUT_CYCLES-1` with round incomplete → RESET. Same edge: `timeout_src <= src_mask & ~(seen | kick)`, `reset_count` += 1 (saturate at 255).
  - Completion in the same cycle as `cnt == TIMEOUT_CYCLES-1` wins: no timeout.
  - `enable`=0 → IDLE; timeout is not taken in that cycle.
- RESET:
  - `reset_out`=1; `kick` ignored.
  - After HOLD_CYCLES cycles → GRACE, or straight to ARMED when GRACE_CYCLES=0.
  - `enable`=0 does not truncate the pulse; at pulse end go to IDLE instead.
- GRACE:
  - `kick` ignored; `seen`=0.
  - After GRACE_CYCLES cycles → ARMED, or IDLE if `enable`=0.
  - `enable`=0 mid-grace → IDLE next cycle.
- `timeout_src` holds its value until the next timeout or `rst`.
- `reset_count` is cleared only by `rst`.
- `rst`:
  - All outputs = 0, state IDLE, `cnt`=0, `seen`=0.
  - Mid-pulse `rst` drops `reset_out` on the next edge.

## Timing

- All outputs registered.
- Cycle numbering: `enable` rises and is sampled at edge 0; ARMED is entered at cycle 1 with `cnt`=0.
- With no kicks:
  - `cnt` = T−1 at cycle T.
  - `reset_out`=1 for cycles T+1 … T+HOLD.
  - GRACE for cycles T+HOLD+1 … T+HOLD+GRACE.
  - ARMED again at T+HOLD+GRACE+1.
- Kick-to-effect: a kick sampled at edge n influences the state at n+1.
- `wdt_state` changes on the same edge as `reset_out`.

## Structure

- Package `wdt_pkg`:
  - `wdt_state_e` enum (2-bit, encodings above).
  - Constants `WDT_CLOCK_FREQ` = 100_000_000 and `WDT_DEFAULT_TIMEOUT_SEC` = 5.
- Sub-module `wdt_kick_tracker`:
  - Inputs: `clk`, `rst`, `clear`, `kick`, `src_mask`.
  - Outputs: `seen`, `all_seen` (combinational, includes the current `kick`), `missing`.
  - The top level holds the FSM, counter and status registers.

## Test plan

All scenarios use NUM_SRC=2, T=10, HOLD=3, GRACE=5.

- No kicks:
  - Stimulus: `enable`=1, `src_mask`=2'b11 at cycle 0.
  - Response: `reset_out` high in cycles 11–13 exactly; `timeout_src`=2'b11; `reset_count`=1; ARMED at cycle 19.
- Completing kicks:
  - Stimulus: `kick[0]` at cycle 3, `kick[1]` at cycle 10 (cnt=9).
  - Response: no reset; `cnt`=0 at cycle 11; repeating the pattern never fires.
- Partial kicks and mask gating:
  - Stimulus: only `kick[0]` is kicked.
  - Response: timeout with `timeout_src`=2'b10.
  - Stimulus: `src_mask`=2'b00 for 100 cycles.
  - Response: `reset_out` stays 0.
- Disable during reset:
  - Stimulus: `enable`→0 at the first RESET cycle.
  - Response: full 3-cycle pulse, then IDLE; `wdt_state`=0.
  - Stimulus: `enable`→0 during GRACE.
  - Response: IDLE on the next cycle.
- Reset mid-operation:
  - Stimulus: `rst` during the second `reset_out` cycle.
  - Response: `reset_out`=0, `reset_count`=0, `timeout_src`=0 on the next edge; state IDLE.
- Saturation:
  - Stimulus: force 260 timeouts.
  - Response: `reset_count` stays at 255; the pulse still fires every time.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog reset sequencer.
// State encodings are visible on wdt_state, so keep them fixed.
package wdt_pkg;

    localparam int unsigned WDT_CLOCK_FREQ          = 100_000_000;
    localparam int unsigned WDT_DEFAULT_TIMEOUT_SEC = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StReset = 2'd2,
        StGrace = 2'd3
    } wdt_state_e;

    function automatic logic [7:0] wdt_sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/wdt_kick_tracker.sv
// Accumulates per-source heartbeats for the current timeout window.
// all_seen and missing include this cycle's kick so a last-cycle kick still counts.
module wdt_kick_tracker
    import wdt_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [NUM_SRC-1:0] kick,
    input  logic [NUM_SRC-1:0] src_mask,
    output logic [NUM_SRC-1:0] seen,
    output logic               all_seen,
    output logic [NUM_SRC-1:0] missing
);

    logic [NUM_SRC-1:0] seen_q;
    logic [NUM_SRC-1:0] seen_d;
    logic [NUM_SRC-1:0] seen_now;

    always_comb begin
        seen_now = seen_q | kick;
        all_seen = (seen_now & src_mask) == src_mask;
        missing  = src_mask & ~seen_now;
        seen_d   = clear ? '0 : (seen_q | (kick & src_mask));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= '0;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign seen = seen_q;

endmodule

// File: rtl/watchdog_reset_sequencer.sv
// Multi-source watchdog: a missed heartbeat window fires a fixed-length reset
// pulse, then a boot grace period, then re-arms automatically.
module watchdog_reset_sequencer
    import wdt_pkg::*;
#(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned TIMEOUT_CYCLES = WDT_CLOCK_FREQ * WDT_DEFAULT_TIMEOUT_SEC,
    parameter int unsigned HOLD_CYCLES    = 1000,
    parameter int unsigned GRACE_CYCLES   = 100_000_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_SRC-1:0] kick,
    input  logic [NUM_SRC-1:0] src_mask,
    output logic               reset_out,
    output logic [1:0]         wdt_state,
    output logic [NUM_SRC-1:0] timeout_src,
    output logic [7:0]         reset_count
);

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(HOLD_CYCLES - 1);
    // GraceLast is unused when GRACE_CYCLES is 0; clamp to avoid underflow.
    localparam logic [CNT_W-1:0] GraceLast   =
        CNT_W'((GRACE_CYCLES == 0) ? 32'd0 : GRACE_CYCLES - 1);

    wdt_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               reset_out_q;
    logic [NUM_SRC-1:0] timeout_src_q, timeout_src_d;
    logic [7:0]         reset_count_q, reset_count_d;

    logic               tracker_clear;
    logic [NUM_SRC-1:0] seen;
    logic               all_seen;
    logic [NUM_SRC-1:0] missing;

    wdt_kick_tracker #(
        .NUM_SRC (NUM_SRC)
    ) u_kick_tracker (
        .clk      (clk),
        .rst      (rst),
        .clear    (tracker_clear),
        .kick     (kick),
        .src_mask (src_mask),
        .seen     (seen),
        .all_seen (all_seen),
        .missing  (missing)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        timeout_src_d = timeout_src_q;
        reset_count_d = reset_count_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // Disable beats completion, completion beats timeout.
                if (!enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (all_seen) begin
                    cnt_d = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d       = StReset;
                    cnt_d         = '0;
                    timeout_src_d = missing;
                    reset_count_d = wdt_sat_inc(reset_count_q);
                end
            end
            StReset: begin
                if (cnt_q == HoldLast) begin
                    cnt_d = '0;
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (GRACE_CYCLES == 0) begin
                        state_d = StArmed;
                    end else begin
                        state_d = StGrace;
                    end
                end
            end
            StGrace: begin
                if (!enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == GraceLast) begin
                    state_d = StArmed;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Heartbeat history only survives while armed and within an open round.
        tracker_clear = (state_q != StArmed) || (state_d != StArmed) || all_seen;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            reset_out_q   <= 1'b0;
            timeout_src_q <= '0;
            reset_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reset_out_q   <= (state_d == StReset);
            timeout_src_q <= timeout_src_d;
            reset_count_q <= reset_count_d;
        end
    end

    assign reset_out   = reset_out_q;
    assign wdt_state   = state_q;
    assign timeout_src = timeout_src_q;
    assign reset_count = reset_count_q;

endmodule

// File: tb/tb_watchdog_reset_sequencer.sv
// Directed bench for watchdog_reset_sequencer: per-cycle vector table plus a
// saturation sequence, with NUM_SRC=2, T=10, HOLD=3, GRACE=5.
module tb_watchdog_reset_sequencer;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RESET = 2'd2;
    localparam logic [1:0] S_GRACE = 2'd3;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] kick;
    logic [1:0] src_mask;
    logic       reset_out;
    logic [1:0] wdt_state;
    logic [1:0] timeout_src;
    logic [7:0] reset_count;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] kick;
        logic [1:0] mask;
        logic       ro;
        logic [1:0] st;
        logic [1:0] ts;
        logic [7:0] rc;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    watchdog_reset_sequencer #(
        .NUM_SRC        (2),
        .TIMEOUT_CYCLES (10),
        .HOLD_CYCLES    (3),
        .GRACE_CYCLES   (5),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .kick        (kick),
        .src_mask    (src_mask),
        .reset_out   (reset_out),
        .wdt_state   (wdt_state),
        .timeout_src (timeout_src),
        .reset_count (reset_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    task automatic add(input int n, input string tag, input logic r, input logic en,
                       input logic [1:0] k, input logic [1:0] m, input logic ro,
                       input logic [1:0] st, input logic [1:0] ts, input logic [7:0] rc);
        vec_t v;
        v.rst = r; v.en = en; v.kick = k; v.mask = m;
        v.ro = ro; v.st = st; v.ts = ts; v.rc = rc; v.tag = tag;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        int   waited;
        int   len;
        logic [7:0] exp_rc;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        kick     = 2'b00;
        src_mask = 2'b00;

        // Reset, then no kicks: pulse in cycles 11..13, grace 14..18, armed at 19.
        add(2,  "reset",      1, 0, 2'b00, 2'b00, 0, S_IDLE,  2'b00, 8'd0);
        add(10, "nokick_arm", 0, 1, 2'b00, 2'b11, 0, S_ARMED, 2'b00, 8'd0);
        add(3,  "nokick_rst", 0, 1, 2'b00, 2'b11, 1, S_RESET, 2'b11, 8'd1);
        add(5,  "nokick_grc", 0, 1, 2'b00, 2'b11, 0, S_GRACE, 2'b11, 8'd1);
        add(1,  "nokick_re",  0, 1, 2'b00, 2'b11, 0, S_ARMED, 2'b11, 8'd1);
        // Completing rounds: kick[0] at cnt=2, kick[1] on the last window cycle.
        for (int r = 1; r <= 30; r++) begin
            add(1, "complete", 0, 1, (r % 10 == 3) ? 2'b01 : (r % 10 == 0) ? 2'b10 : 2'b00,
                2'b11, 0, S_ARMED, 2'b11, 8'd1);
        end
        // Only source 0 kicks; then disable at the first reset cycle.
        add(9,  "partial_arm", 0, 1, 2'b01, 2'b11, 0, S_ARMED, 2'b11, 8'd1);
        add(1,  "partial_to",  0, 1, 2'b01, 2'b11, 1, S_RESET, 2'b10, 8'd2);
        add(2,  "dis_pulse",   0, 0, 2'b00, 2'b11, 1, S_RESET, 2'b10, 8'd2);
        add(2,  "dis_idle",    0, 0, 2'b00, 2'b11, 0, S_IDLE,  2'b10, 8'd2);
        // Timeout again, then disable in the middle of grace.
        add(10, "grc_arm",     0, 1, 2'b00, 2'b11, 0, S_ARMED, 2'b10, 8'd2);
        add(3,  "grc_rst",     0, 1, 2'b00, 2'b11, 1, S_RESET, 2'b11, 8'd3);
        add(2,  "grc_grace",   0, 1, 2'b00, 2'b11, 0, S_GRACE, 2'b11, 8'd3);
        add(2,  "grc_dis",     0, 0, 2'b00, 2'b11, 0, S_IDLE,  2'b11, 8'd3);
        // Empty mask never times out.
        add(101, "mask0",      0, 1, 2'b00, 2'b00, 0, S_ARMED, 2'b11, 8'd3);
        // Timeout, then rst during the second pulse cycle.
        add(9,  "mid_arm",     0, 1, 2'b00, 2'b11, 0, S_ARMED, 2'b11, 8'd3);
        add(2,  "mid_rst",     0, 1, 2'b00, 2'b11, 1, S_RESET, 2'b11, 8'd4);
        add(1,  "mid_clear",   1, 1, 2'b00, 2'b11, 0, S_IDLE,  2'b00, 8'd0);
        add(1,  "mid_idle",    0, 0, 2'b00, 2'b11, 0, S_IDLE,  2'b00, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            enable   = vecs[i].en;
            kick     = vecs[i].kick;
            src_mask = vecs[i].mask;
            @(posedge clk);
            #1;
            check({vecs[i].tag, ".reset_out"},   i, {7'd0, reset_out},   {7'd0, vecs[i].ro});
            check({vecs[i].tag, ".wdt_state"},   i, {6'd0, wdt_state},   {6'd0, vecs[i].st});
            check({vecs[i].tag, ".timeout_src"}, i, {6'd0, timeout_src}, {6'd0, vecs[i].ts});
            check({vecs[i].tag, ".reset_count"}, i, reset_count,         vecs[i].rc);
        end

        // Saturation: 260 back-to-back timeouts, counter sticks at 255.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        enable   = 1'b1;
        kick     = 2'b00;
        src_mask = 2'b11;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 260; n++) begin
            waited = 0;
            while (!reset_out && waited < 40) begin
                @(posedge clk);
                #1;
                waited++;
            end
            check("sat.pulse_fired", n, {7'd0, reset_out}, 8'd1);
            exp_rc = (n > 255) ? 8'd255 : 8'(n);
            check("sat.reset_count", n, reset_count, exp_rc);
            len = 1;
            while (reset_out && len < 10) begin
                @(posedge clk);
                #1;
                if (reset_out) len++;
                else break;
            end
            check("sat.pulse_len", n, 8'(len), 8'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
